// File: rtl/mcb_resp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : mcb_resp_pkg                                           |
// | Description : Shared opcodes, FSM state encoding and command-FIFO    |
// |               depth for the MCB port responder.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package mcb_resp_pkg;

   // Command opcodes as seen on cmd_instr
   localparam logic [2:0] OP_WRITE    = 3'b000;
   localparam logic [2:0] OP_READ     = 3'b001;
   localparam logic [2:0] OP_WRITE_AP = 3'b010;
   localparam logic [2:0] OP_READ_AP  = 3'b011;
   localparam logic [2:0] OP_REFRESH  = 3'b100;

   // Number of commands that can be queued ahead of the engine
   localparam int CMD_DEPTH = 4;

   // Burst engine states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } fsm_state_t;

   // Both plain and auto-precharge writes move data into memory
   function automatic logic is_write_op(input logic [2:0] op);
      return (op == OP_WRITE) || (op == OP_WRITE_AP);
   endfunction

   // Both plain and auto-precharge reads move data out of memory
   function automatic logic is_read_op(input logic [2:0] op);
      return (op == OP_READ) || (op == OP_READ_AP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mcb_port_responder_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sync_fifo                                              |
// | Description : Single-clock first-word-fall-through FIFO with exact   |
// |               occupancy count. Push while full and pop while empty   |
// |               are ignored; dout reads zero while empty.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push,
   input  logic [WIDTH-1:0]               din,
   input  logic                           pop,
   output logic [WIDTH-1:0]               dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store [0:DEPTH-1];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // Head word falls through; forced to zero when there is no valid head
   assign dout    = empty ? '0 : store[rptr];

   // Storage array, not reset: only the pointers define validity
   always_ff @(posedge clk) begin
      if (do_push) begin
         store[wptr] <= din;
      end
   end

   // Pointer and occupancy tracking; simultaneous push and pop keeps count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) begin
            wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
         end
         if (do_pop) begin
            rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mcb_port_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mcb_port_responder                                     |
// | Description : Behavioural responder for an MCB user port: queues     |
// |               commands, executes write/read bursts against a         |
// |               2^MEM_AW x 32-bit synchronous memory.                  |
// | Options     : MCB_RESP_OVERFLOW_EN - reads never stall; words that   |
// |               meet a full read FIFO are dropped and flagged.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module mcb_port_responder
   import mcb_resp_pkg::*;
#(
   parameter int MEM_AW     = 10,
   parameter int DATA_DEPTH = 64
) (
   input  logic                               clk,
   input  logic                               rst_n,
   // command port
   input  logic                               cmd_en,
   input  logic [2:0]                         cmd_instr,
   input  logic [5:0]                         cmd_bl,
   input  logic [29:0]                        cmd_byte_addr,
   output logic                               cmd_empty,
   output logic                               cmd_full,
   // write-data port
   input  logic                               wr_en,
   input  logic [3:0]                         wr_mask,
   input  logic [31:0]                        wr_data,
   output logic                               wr_full,
   output logic                               wr_empty,
   output logic [$clog2(DATA_DEPTH+1)-1:0]    wr_count,
   output logic                               wr_underrun,
   output logic                               wr_error,
   // read-data port
   input  logic                               rd_en,
   output logic [31:0]                        rd_data,
   output logic                               rd_full,
   output logic                               rd_empty,
   output logic [$clog2(DATA_DEPTH+1)-1:0]    rd_count,
   output logic                               rd_overflow,
   output logic                               rd_error
);

   localparam int CW     = $clog2(DATA_DEPTH + 1);
   localparam int CMD_W  = 3 + 6 + MEM_AW;
   localparam int MEM_WORDS = 1 << MEM_AW;

   // Command queue: {opcode, burst-1, start word address}
   logic [CMD_W-1:0]              cmd_head;
   logic                          cmd_pop;
   logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count_unused;
   logic [2:0]                    head_instr;
   logic [5:0]                    head_bl;
   logic [MEM_AW-1:0]             head_addr;

   // Write data queue: {mask, data}
   logic [35:0]                   wr_head;
   logic                          wr_pop;

   // Burst engine
   fsm_state_t                    state;
   logic [MEM_AW-1:0]             addr;
   logic [5:0]                    remaining;
   logic                          rd_issue;
   logic                          rd_stall;
   logic                          rd_pending;
   logic [31:0]                   mem_rdata;
   logic [31:0]                   mem [0:MEM_WORDS-1];

   // Byte-address bits that do not select a word in this memory
   logic                          unused_addr_bits;
   assign unused_addr_bits = ^{cmd_byte_addr[29:MEM_AW+2], cmd_byte_addr[1:0]};

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (CMD_DEPTH)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_en),
      .din   ({cmd_instr, cmd_bl, cmd_byte_addr[MEM_AW+1:2]}),
      .pop   (cmd_pop),
      .dout  (cmd_head),
      .full  (cmd_full),
      .empty (cmd_empty),
      .count (cmd_count_unused)
   );

   sync_fifo #(
      .WIDTH (36),
      .DEPTH (DATA_DEPTH)
   ) u_wr_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_en),
      .din   ({wr_mask, wr_data}),
      .pop   (wr_pop),
      .dout  (wr_head),
      .full  (wr_full),
      .empty (wr_empty),
      .count (wr_count)
   );

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (DATA_DEPTH)
   ) u_rd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rd_pending),
      .din   (mem_rdata),
      .pop   (rd_en),
      .dout  (rd_data),
      .full  (rd_full),
      .empty (rd_empty),
      .count (rd_count)
   );

   assign head_instr = cmd_head[CMD_W-1 -: 3];
   assign head_bl    = cmd_head[MEM_AW +: 6];
   assign head_addr  = cmd_head[MEM_AW-1:0];

   assign cmd_pop     = (state == ST_IDLE) & ~cmd_empty;
   assign wr_pop      = (state == ST_WRITE) & ~wr_empty;
   assign wr_underrun = (state == ST_WRITE) & wr_empty;
   assign rd_issue    = (state == ST_READ) & ~rd_stall;

`ifdef MCB_RESP_OVERFLOW_EN
   // Reads free-run; a returning word that finds the FIFO full is lost
   assign rd_stall    = 1'b0;
   assign rd_overflow = rd_pending & rd_full;
`else
   // Hold off issuing while the in-flight word would have nowhere to land
   assign rd_stall    = ({1'b0, rd_count} + {{CW{1'b0}}, rd_pending}) >= (CW+1)'(DATA_DEPTH);
   assign rd_overflow = 1'b0;
`endif

   // Burst sequencer: pick up a command, walk the burst, return to idle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         addr       <= '0;
         remaining  <= '0;
         rd_pending <= 1'b0;
      end else begin
         rd_pending <= rd_issue;
         case (state)
            ST_IDLE: begin
               if (!cmd_empty) begin
                  addr      <= head_addr;
                  remaining <= head_bl;
                  if (is_write_op(head_instr)) begin
                     state <= ST_WRITE;
                  end else if (is_read_op(head_instr)) begin
                     state <= ST_READ;
                  end
                  // refresh and unknown opcodes are simply consumed
               end
            end
            ST_WRITE: begin
               if (wr_pop) begin
                  addr <= addr + 1'b1;
                  if (remaining == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            ST_READ: begin
               if (rd_issue) begin
                  addr <= addr + 1'b1;
                  if (remaining == '0) begin
                     state <= ST_IDLE;
                  end else begin
                     remaining <= remaining - 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Backing memory: masked byte writes, registered read; survives reset
   always_ff @(posedge clk) begin
      if (wr_pop) begin
         for (int b = 0; b < 4; b++) begin
            if (!wr_head[32+b]) begin
               mem[addr][8*b +: 8] <= wr_head[8*b +: 8];
            end
         end
      end
      if (rd_issue) begin
         mem_rdata <= mem[addr];
      end
   end

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_error <= 1'b0;
         rd_error <= 1'b0;
      end else begin
         if ((wr_en && wr_full) || wr_underrun) begin
            wr_error <= 1'b1;
         end
         if ((rd_en && rd_empty) || rd_overflow) begin
            rd_error <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mcb_port_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mcb_port_responder                                  |
// | Description : Self-checking bench for mcb_port_responder. A memory   |
// |               model produces expected read words into a scoreboard   |
// |               queue that is drained as the DUT returns data.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_mcb_port_responder;

   localparam int MEM_AW     = 10;
   localparam int DATA_DEPTH = 64;
   localparam int MEM_WORDS  = 1 << MEM_AW;

   logic        clk;
   logic        rst_n;
   logic        cmd_en;
   logic [2:0]  cmd_instr;
   logic [5:0]  cmd_bl;
   logic [29:0] cmd_byte_addr;
   logic        cmd_empty;
   logic        cmd_full;
   logic        wr_en;
   logic [3:0]  wr_mask;
   logic [31:0] wr_data;
   logic        wr_full;
   logic        wr_empty;
   logic [6:0]  wr_count;
   logic        wr_underrun;
   logic        wr_error;
   logic        rd_en;
   logic [31:0] rd_data;
   logic        rd_full;
   logic        rd_empty;
   logic [6:0]  rd_count;
   logic        rd_overflow;
   logic        rd_error;

   int          checks;
   int          failures;
   logic [31:0] model [0:MEM_WORDS-1];
   logic [31:0] exp_q [$];

   mcb_port_responder #(
      .MEM_AW     (MEM_AW),
      .DATA_DEPTH (DATA_DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cmd_en        (cmd_en),
      .cmd_instr     (cmd_instr),
      .cmd_bl        (cmd_bl),
      .cmd_byte_addr (cmd_byte_addr),
      .cmd_empty     (cmd_empty),
      .cmd_full      (cmd_full),
      .wr_en         (wr_en),
      .wr_mask       (wr_mask),
      .wr_data       (wr_data),
      .wr_full       (wr_full),
      .wr_empty      (wr_empty),
      .wr_count      (wr_count),
      .wr_underrun   (wr_underrun),
      .wr_error      (wr_error),
      .rd_en         (rd_en),
      .rd_data       (rd_data),
      .rd_full       (rd_full),
      .rd_empty      (rd_empty),
      .rd_count      (rd_count),
      .rd_overflow   (rd_overflow),
      .rd_error      (rd_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] instr, input logic [5:0] bl, input logic [29:0] baddr);
      cmd_en        = 1'b1;
      cmd_instr     = instr;
      cmd_bl        = bl;
      cmd_byte_addr = baddr;
      tick();
      cmd_en        = 1'b0;
   endtask

   task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
      wr_en   = 1'b1;
      wr_data = d;
      wr_mask = m;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic model_write(input int wa, input logic [31:0] d, input logic [3:0] m);
      for (int b = 0; b < 4; b++) begin
         if (!m[b]) model[wa % MEM_WORDS][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic expect_read(input int wa, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(model[(wa + i) % MEM_WORDS]);
   endtask

   task automatic drain(input string tag);
      int want;
      int got;
      int budget;
      want   = exp_q.size();
      got    = 0;
      budget = 0;
      while (got < want && budget < 500) begin
         if (!rd_empty) begin
            check(tag, rd_data, exp_q.pop_front());
            rd_en = 1'b1;
            got++;
         end else begin
            rd_en = 1'b0;
         end
         tick();
         budget++;
      end
      rd_en = 1'b0;
      if (got < want) begin
         check({tag, "_timeout"}, got, want);
         exp_q.delete();
      end
   endtask

   initial begin
      int ov_cycles;
      int lat;
      checks        = 0;
      failures      = 0;
      rst_n         = 1'b0;
      cmd_en        = 1'b0;
      cmd_instr     = '0;
      cmd_bl        = '0;
      cmd_byte_addr = '0;
      wr_en         = 1'b0;
      wr_mask       = '0;
      wr_data       = '0;
      rd_en         = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) model[i] = '0;

      // ---- reset values ----
      repeat (3) tick();
      check("rst_cmd_empty", cmd_empty, 1);
      check("rst_cmd_full", cmd_full, 0);
      check("rst_wr_empty", wr_empty, 1);
      check("rst_wr_full", wr_full, 0);
      check("rst_wr_count", wr_count, 0);
      check("rst_rd_empty", rd_empty, 1);
      check("rst_rd_full", rd_full, 0);
      check("rst_rd_count", rd_count, 0);
      check("rst_wr_underrun", wr_underrun, 0);
      check("rst_rd_overflow", rd_overflow, 0);
      check("rst_wr_error", wr_error, 0);
      check("rst_rd_error", rd_error, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      tick();

      // ---- fill words 0..63 with one full-depth write burst ----
      for (int i = 0; i < 64; i++) begin
         push_wr(32'hC0DE_0000 | i, 4'b0000);
         model_write(i, 32'hC0DE_0000 | i, 4'b0000);
      end
      check("fill_wr_count", wr_count, 64);
      check("fill_wr_full", wr_full, 1);
      send_cmd(3'b000, 6'd63, 30'h0);
      repeat (80) tick();
      check("fill_wr_empty", wr_empty, 1);
      check("fill_wr_count0", wr_count, 0);

      // ---- four-word write then read back at 0x40 ----
      for (int i = 0; i < 4; i++) begin
         push_wr(32'h1111_1111 * (i + 1), 4'b0000);
         model_write(16 + i, 32'h1111_1111 * (i + 1), 4'b0000);
      end
      check("b4_wr_count", wr_count, 4);
      send_cmd(3'b000, 6'd3, 30'h40);
      repeat (10) tick();
      check("b4_wr_empty", wr_empty, 1);
      send_cmd(3'b001, 6'd3, 30'h40);
      expect_read(16, 4);
      repeat (10) tick();
      check("b4_rd_count", rd_count, 4);
      drain("b4_data");

      // ---- byte mask merge; mask listed bit0 first, 0101 -> 4'b1010 ----
      push_wr(32'hAABB_CCDD, 4'b0000);
      model_write(0, 32'hAABB_CCDD, 4'b0000);
      send_cmd(3'b000, 6'd0, 30'h0);
      repeat (6) tick();
      push_wr(32'h1122_3344, 4'b1010);
      model_write(0, 32'h1122_3344, 4'b1010);
      send_cmd(3'b000, 6'd0, 30'h0);
      repeat (6) tick();
      send_cmd(3'b001, 6'd0, 30'h0);
      exp_q.push_back(32'hAA22_CC44);
      repeat (6) tick();
      drain("mask_data");

      // ---- write underrun, then refresh/unknown opcodes consumed ----
      push_wr(32'h0BAD_0001, 4'b0000);
      send_cmd(3'b010, 6'd1, 30'h100);
      repeat (6) tick();
      check("ur_underrun", wr_underrun, 1);
      check("ur_wr_error", wr_error, 1);
      push_wr(32'h0BAD_0002, 4'b0000);
      model_write(64, 32'h0BAD_0001, 4'b0000);
      model_write(65, 32'h0BAD_0002, 4'b0000);
      repeat (3) tick();
      check("ur_underrun_clr", wr_underrun, 0);
      check("ur_wr_empty", wr_empty, 1);
      send_cmd(3'b100, 6'd5, 30'h0);
      send_cmd(3'b111, 6'd5, 30'h0);
      send_cmd(3'b011, 6'd1, 30'h100);
      expect_read(64, 2);
      repeat (8) tick();
      check("ur_cmd_empty", cmd_empty, 1);
      drain("ur_data");
      check("ur_wr_error_sticky", wr_error, 1);

      // ---- read FIFO fill to capacity, then one more word ----
      send_cmd(3'b001, 6'd63, 30'h0);
      expect_read(0, 64);
      repeat (80) tick();
      check("full_rd_full", rd_full, 1);
      check("full_rd_count", rd_count, 64);
      send_cmd(3'b001, 6'd0, 30'h14);
      ov_cycles = 0;
      for (int i = 0; i < 10; i++) begin
         if (rd_overflow) ov_cycles++;
         tick();
      end
      check("full_rd_count2", rd_count, 64);
`ifdef MCB_RESP_OVERFLOW_EN
      check("ov_pulses", ov_cycles, 1);
      check("ov_rd_error", rd_error, 1);
`else
      check("ov_pulses", ov_cycles, 0);
      check("ov_rd_error", rd_error, 0);
      expect_read(5, 1);
`endif
      drain("full_data");

      // ---- address wrap: byte address 4*2^MEM_AW lands on word 0 ----
      push_wr(32'h5A5A_0001, 4'b0000);
      model_write(0, 32'h5A5A_0001, 4'b0000);
      send_cmd(3'b000, 6'd0, 30'(4 * MEM_WORDS));
      repeat (6) tick();
      send_cmd(3'b001, 6'd0, 30'h0);
      expect_read(0, 1);
      repeat (6) tick();
      drain("wrap_data");

      // ---- read while empty sets the sticky read error ----
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("rd_err_empty", rd_error, 1);

      // ---- asynchronous reset in the middle of a 32-word read ----
      send_cmd(3'b001, 6'd31, 30'h0);
      repeat (5) tick();
      check("mid_rd_busy", rd_empty, 0);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_rd_empty", rd_empty, 1);
      check("arst_rd_count", rd_count, 0);
      check("arst_rd_data", rd_data, 0);
      check("arst_cmd_empty", cmd_empty, 1);
      check("arst_wr_error", wr_error, 0);
      check("arst_rd_error", rd_error, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      exp_q.delete();
      repeat (3) tick();
      check("post_rd_empty", rd_empty, 1);

      // ---- fresh read after reset, with issue-to-data latency ----
      send_cmd(3'b001, 6'd0, 30'h40);
      expect_read(16, 1);
      lat = 0;
      while (rd_empty && lat < 10) begin
         tick();
         lat++;
      end
      check("lat_le_3", (lat <= 3) ? 32'd1 : 32'd0, 1);
      drain("post_data");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mcb_port_responder.md
MCB_PORT_RESPONDER -- requirements
Module: mcb_port_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 10: backing-memory word-address width, giving 1024 x 32-bit words.
REQ-002 SHALL have parameter DATA_DEPTH, default 64: depth of the write-data and read-data FIFOs.
REQ-003 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have command inputs: cmd_en  in  1  push command; cmd_instr  in  3  opcode; cmd_bl  in  6  burst length minus 1; cmd_byte_addr  in  30  byte address.
REQ-005 SHALL have command status outputs: cmd_empty  out  1; cmd_full  out  1.
REQ-006 SHALL have write-data inputs: wr_en  in  1; wr_mask  in  4  (1 = byte not written); wr_data  in  32.
REQ-007 SHALL have write-data status outputs: wr_full  out  1; wr_empty  out  1; wr_count  out  7; wr_underrun  out  1; wr_error  out  1.
REQ-008 SHALL have read-data ports: rd_en  in  1; rd_data  out  32; rd_full  out  1; rd_empty  out  1; rd_count  out  7; rd_overflow  out  1; rd_error  out  1.

Function
REQ-009 SHALL hold accepted commands in a 4-entry command FIFO, and SHALL silently drop cmd_en while cmd_full is high.
REQ-010 SHALL decode opcodes as: 000 and 010 = write; 001 and 011 = read; 100 = refresh, consumed with no memory access; any other code = consumed and ignored.
REQ-011 SHALL set burst length to cmd_bl+1 words (1..64).
REQ-012 SHALL take the start word address from cmd_byte_addr[MEM_AW+1:2], ignoring bits [1:0], incrementing by one per word and wrapping modulo 2^MEM_AW.
REQ-013 SHALL run an FSM with states IDLE, WRITE and READ.
- IDLE: when the command FIFO is not empty, pop one command and go to WRITE or READ (refresh and unknown opcodes stay in IDLE).
- Return to IDLE after the last burst word.
REQ-014 In WRITE, SHALL, per cycle that the write FIFO is not empty, pop one word and write only the bytes whose mask bit is 0.
REQ-015 In WRITE with the write FIFO empty, SHALL hold wr_underrun high for that cycle, stall, and set wr_error.
REQ-016 In READ, SHALL read one word per cycle from synchronous memory (1-cycle latency) and push it into the read FIFO.
REQ-017 SHALL reach rd_empty=0 no later than 3 cycles after the cmd_en edge of a read issued to an idle block.
REQ-018 SHALL make rd_data show the head of the read FIFO (first-word fall-through) and SHALL pop one word on rd_en while rd_empty is low.
REQ-019 SHALL drop wr_en while wr_full is high and set wr_error; SHALL ignore rd_en while rd_empty is high and set rd_error.
REQ-020 SHALL report wr_count and rd_count as exact occupancy, 0..DATA_DEPTH; full/empty SHALL be exact at 0 and DATA_DEPTH.
REQ-021 SHALL honour a push and a pop on the same FIFO in the same cycle, at any occupancy other than the blocked cases, leaving the count unchanged.
REQ-022 SHALL keep wr_error and rd_error sticky until reset.

Reset
REQ-023 While rst_n is low, SHALL force:
- all FIFOs empty: cmd_empty=1, wr_empty=1, rd_empty=1, cmd_full=0, wr_full=0, rd_full=0, wr_count=0, rd_count=0;
- wr_underrun=0, rd_overflow=0, wr_error=0, rd_error=0, rd_data=0;
- the FSM to IDLE.
REQ-024 SHALL not clear memory contents on reset; reset during a burst SHALL abandon the remaining words.

Configuration
REQ-025 Without MCB_RESP_OVERFLOW_EN, SHALL make READ stall while rd_full is high, and rd_overflow SHALL be tied to 0.
REQ-026 With MCB_RESP_OVERFLOW_EN, SHALL make READ never stall: a word that meets rd_full is discarded, rd_overflow pulses for 1 cycle and rd_error is set.

Structure
REQ-027 Package mcb_resp_pkg SHALL hold the opcode constants, the FSM state enum and the command-FIFO depth of 4.
REQ-028 Sub-module sync_fifo (parameterised width/depth, FWFT, count output) SHALL be instantiated for the command, write and read FIFOs.

Verification
REQ-029 SHALL cover: push 4 words 0x11111111..0x44444444, write cmd bl=3 at addr 0x40, then read cmd bl=3 at 0x40 -> rd_count=4, data returned in order.
REQ-030 SHALL cover: write 0xAABBCCDD to 0x0 with mask 0000, then 0x11223344 with mask 0101 -> read returns 0xAA22CC44.
REQ-031 SHALL cover: write cmd bl=1 with 1 data word queued -> wr_underrun high for 1+ cycles, wr_error=1; after the 2nd word is pushed the FSM returns to IDLE.
REQ-032 SHALL cover: read bl=63 with no rd_en and DATA_DEPTH=64 -> rd_full=1, rd_count=64; without the macro no loss occurs; with the macro a 65th word from a second read bl=0 is dropped, rd_overflow pulses and rd_error=1.
REQ-033 SHALL cover: write bl=0 at byte address 4*(2^MEM_AW) -> the data lands at word 0 (wrap).
REQ-034 SHALL cover: rst_n dropped mid-burst of 32-word read -> all outputs at reset values asynchronously, and a new command works after release.
